hazard_ctrl: RTL

Pipeline hazard and forwarding controller for the five-stage MIPS core. It generates the forwarding selects and the stall that the decode stage consumes. It receives decoded register-usage information for the instruction in D and keeps an internal scoreboard of the E, M and W occupants. From that scoreboard it produces the D-stage and E-stage forwarding mux selects, the F/D stall, and the multiply/divide busy interlock.

---
 rtl/hazard_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl
// ----------------------------------------------------------------------------
// Hazard and forwarding controller for the five-stage MIPS pipeline.
// It keeps a small scoreboard of the instructions in E, M and W.
// From that scoreboard and the decoded register usage of the instruction
// in D it produces:
//   - the D-stage forwarding selects,
//   - the E-stage forwarding selects,
//   - the F/D stall,
//   - the multiply/divide busy interlock.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high; clears scoreboard and busy counter
//   rs_D, rt_D     source register fields of the D instruction
//   tuse_rs_D/rt_D cycles until operand is needed (0=D, 1=E, 2=M, 3=unused)
//   dst_D          destination register of the D instruction (0 = none)
//   tnew_D         cycles from E entry until the result exists
//   mdu_start_D    0=none, 1=mult-class, 2=div-class
//   mdu_use_D      D instruction touches HI/LO or starts the MDU
//   flush          squashes the E, M and W occupants
//   stall          hold PC and F/D, inject a bubble into E
//   regRD1Forward  D rs select: 0=GRF, 1=EX result, 2=MEM result
//   regRD2Forward  D rt select, same encoding
//   fwdA_E         E rs select: 0=pipeline register, 1=MEM result, 2=WB result
//   fwdB_E         E rt select, same encoding
//   mdu_busy       multiply/divide unit still computing
//
// MULT_CYCLES and DIV_CYCLES must fit the 4-bit busy counter (<= 15).
// ============================================================================
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs_D,
    input  logic [1:0] tuse_rt_D,
    input  logic [4:0] dst_D,
    input  logic [1:0] tnew_D,
    input  logic [1:0] mdu_start_D,
    input  logic       mdu_use_D,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] regRD1Forward,
    output logic [1:0] regRD2Forward,
    output logic [1:0] fwdA_E,
    output logic [1:0] fwdB_E,
    output logic       mdu_busy
);

    typedef enum logic [1:0] {
        MDU_NONE = 2'd0,
        MDU_MULT = 2'd1,
        MDU_DIV  = 2'd2
    } mdu_kind_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    // Scoreboard: E keeps full usage info, M only what later forwarding needs.
    logic [4:0] e_rs;
    logic [4:0] e_rt;
    logic [4:0] e_dst;
    logic [1:0] e_tnew;
    logic [1:0] e_start;
    logic [4:0] m_dst;
    logic [1:0] m_tnew;
    logic [4:0] w_dst;
    logic [3:0] busy_cnt;

    logic rs_hazard;
    logic rt_hazard;
    logic mdu_hazard;

    // D-side select: a result is usable once its remaining tnew reaches 0.
    // E is checked first because it holds the younger writer.
    function automatic logic [1:0] fwd_d_sel(input logic [4:0] src,
                                             input logic [4:0] ed,
                                             input logic [1:0] et,
                                             input logic [4:0] md,
                                             input logic [1:0] mt);
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (src == ed && et == 2'd0)
                sel = 2'd1;
            else if (src == md && mt == 2'd0)
                sel = 2'd2;
        end
        return sel;
    endfunction

    // E-side select: W always has its result, M only when its tnew is 0.
    function automatic logic [1:0] fwd_e_sel(input logic [4:0] src,
                                             input logic [4:0] md,
                                             input logic [1:0] mt,
                                             input logic [4:0] wd);
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (src == md && mt == 2'd0)
                sel = 2'd1;
            else if (src == wd)
                sel = 2'd2;
        end
        return sel;
    endfunction

    // An operand must wait while a producer still needs more cycles than the
    // consumer can tolerate before reading it.
    function automatic logic data_hazard(input logic [4:0] src,
                                         input logic [1:0] tuse,
                                         input logic [4:0] ed,
                                         input logic [1:0] et,
                                         input logic [4:0] md,
                                         input logic [1:0] mt);
        logic hit;
        hit = 1'b0;
        if (src != 5'd0 && tuse != 2'd3) begin
            if (src == ed && et > tuse)
                hit = 1'b1;
            if (src == md && mt > tuse)
                hit = 1'b1;
        end
        return hit;
    endfunction

    // All outputs are pure functions of the scoreboard and the D inputs.
    always_comb begin
        rs_hazard     = data_hazard(rs_D, tuse_rs_D, e_dst, e_tnew, m_dst, m_tnew);
        rt_hazard     = data_hazard(rt_D, tuse_rt_D, e_dst, e_tnew, m_dst, m_tnew);
        mdu_busy      = (busy_cnt != 4'd0);
        mdu_hazard    = mdu_use_D && ((e_start != MDU_NONE) || mdu_busy);
        stall         = rs_hazard || rt_hazard || mdu_hazard;
        regRD1Forward = fwd_d_sel(rs_D, e_dst, e_tnew, m_dst, m_tnew);
        regRD2Forward = fwd_d_sel(rt_D, e_dst, e_tnew, m_dst, m_tnew);
        fwdA_E        = fwd_e_sel(e_rs, m_dst, m_tnew, w_dst);
        fwdB_E        = fwd_e_sel(e_rt, m_dst, m_tnew, w_dst);
    end

    // Scoreboard advance. Flush wipes every in-flight entry instead of
    // shifting; a stall turns the E slot into a bubble.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            e_rs    <= 5'd0;
            e_rt    <= 5'd0;
            e_dst   <= 5'd0;
            e_tnew  <= 2'd0;
            e_start <= 2'd0;
            m_dst   <= 5'd0;
            m_tnew  <= 2'd0;
            w_dst   <= 5'd0;
        end else begin
            w_dst  <= m_dst;
            m_dst  <= e_dst;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            if (stall) begin
                e_rs    <= 5'd0;
                e_rt    <= 5'd0;
                e_dst   <= 5'd0;
                e_tnew  <= 2'd0;
                e_start <= 2'd0;
            end else begin
                e_rs    <= rs_D;
                e_rt    <= rt_D;
                e_dst   <= dst_D;
                e_tnew  <= tnew_D;
                e_start <= mdu_start_D;
            end
        end
    end

    // MDU busy counter. It loads when a start leaves E; a flush squashes that
    // start but lets an operation already in progress count down normally.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 4'd0;
        end else if (!flush && e_start != MDU_NONE) begin
            busy_cnt <= (e_start == MDU_MULT) ? MULT_LOAD : DIV_LOAD;
        end else if (busy_cnt != 4'd0) begin
            busy_cnt <= busy_cnt - 4'd1;
        end
    end

endmodule
